// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller that feeds the combinational 16-bit ALU.
//   Decodes 16-bit instruction words into an ALU opcode and A/B/carry operands,
//   captures the ALU result and flags, and writes back to a 16x16 register file and the 5-bit PSR.
//   Optional macro ALU_ISSUE_FAST_EN merges READ and EXEC into one state and drives the ALU inputs combinationally.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   inst_valid/inst_ready     instruction handshake (ready only in IDLE)
//   inst                      {op, Rdest, ext, Rsrc} or {op, Rdest, imm8}
//   alu_opcode/a/b/carry      ALU inputs
//   alu_c, alu_flags          ALU result and flags {Z,C,F,L,N}
//   psr                       processor status register
//   done, illegal             one-cycle writeback pulse, and its undefined-opcode qualifier
//   dbg_raddr/dbg_rdata       combinational register file read port
module alu_issue_ctrl #(
    parameter int NREGS = 16,
    parameter int IMM_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [15:0] inst,
    output logic [7:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_carry,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_raddr,
    output logic [15:0] dbg_rdata
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    state_t      state;
    logic [15:0] inst_q, res_q;
    logic [4:0]  flg_q;
    logic [15:0] regs [NREGS];
    logic [3:0]  op, rd, rs;
    logic [7:0]  dec_op;
    logic [15:0] dec_a, dec_b, imm_s, imm_z;
    logic        legal, sext, upd, no_wb;
    assign op     = inst_q[15:12];
    assign rd     = inst_q[11:8];
    assign rs     = inst_q[3:0];
    assign dec_op = (op == 4'h0 || op == 4'h8) ? {op, inst_q[7:4]} : {op, 4'h0};
    assign imm_s  = {{(16-IMM_W){inst_q[IMM_W-1]}}, inst_q[IMM_W-1:0]};
    assign imm_z  = {{(16-IMM_W){1'b0}}, inst_q[IMM_W-1:0]};
    // ADDI, ADDCI, SUBI and CMPI take a signed immediate
    assign sext   = op inside {4'h5, 4'h7, 4'h9, 4'hB};
    assign dec_a  = (dec_op == 8'h0F) ? regs[rs] : regs[rd];
    // shifts: ext[2] selects register amount (0x84-0x87) over the 4-bit immediate (0x80-0x83)
    assign dec_b  = (op == 4'h0) ? regs[rs] :
                    (op == 4'h8) ? (inst_q[6] ? regs[rs] : {12'h000, rs}) :
                    sext ? imm_s : imm_z;
    assign legal  = (op == 4'h0) ? !(inst_q[7:4] inside {4'hA, 4'hC, 4'hD, 4'hE}) :
                    (op == 4'h8) ? !inst_q[7] :
                    !(op inside {4'h4, 4'hD, 4'hE, 4'hF});
    assign upd    = legal && dec_op != 8'h00;
    // compares (CMP, CMPU, CMPI, CMPUI) only update flags
    assign no_wb  = dec_op inside {8'h0B, 8'h08, 8'hB0, 8'hC0};
    assign inst_ready = state == IDLE;
    assign alu_carry  = psr[3];
    assign dbg_rdata  = regs[dbg_raddr];
`ifdef ALU_ISSUE_FAST_EN
    assign alu_opcode = dec_op;
    assign alu_a      = dec_a;
    assign alu_b      = dec_b;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            inst_q  <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            psr     <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifndef ALU_ISSUE_FAST_EN
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: if (inst_valid) begin
                    inst_q <= inst;
                    state  <= READ;
                end
`ifdef ALU_ISSUE_FAST_EN
                READ, EXEC: begin
`else
                READ: begin
                    alu_opcode <= dec_op;
                    alu_a      <= dec_a;
                    alu_b      <= dec_b;
                    state      <= EXEC;
                end
                EXEC: begin
`endif
                    res_q   <= alu_c;
                    flg_q   <= alu_flags;
                    done    <= 1'b1;
                    illegal <= !legal;
                    state   <= WB;
                end
                WB: begin
                    if (upd && !no_wb) regs[rd] <= res_q;
                    if (upd) psr <= flg_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a behavioural ALU model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0, inst_valid = 1'b0;
    logic [15:0] inst = '0;
    logic        inst_ready, alu_carry, done, illegal;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_c, dbg_rdata;
    logic [4:0]  alu_flags, psr;
    logic [3:0]  dbg_raddr = '0;
    logic [16:0] sum;
    int checks = 0, errors = 0;
`ifdef ALU_ISSUE_FAST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    alu_issue_ctrl dut (
        .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_carry(alu_carry), .alu_c(alu_c), .alu_flags(alu_flags), .psr(psr),
        .done(done), .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // ALU model, flags {Z,C,F,L,N}
    always_comb begin
        sum = '0;
        alu_c = '0;
        alu_flags = '0;
        case (alu_opcode)
            8'h05, 8'h50: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = sum[15:0];
                alu_flags = {sum[15:0] == 16'h0, sum[16], (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]), 2'b00};
            end
            8'h06, 8'h60: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = sum[15:0];
                alu_flags = {sum[15:0] == 16'h0, sum[16], 3'b000};
            end
            8'h04: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_carry};
                alu_c = sum[15:0];
                alu_flags = {sum[15:0] == 16'h0, sum[16], 3'b000};
            end
            8'h0B, 8'hB0: alu_flags = {alu_a == alu_b, 2'b00, alu_a < alu_b, $signed(alu_a) < $signed(alu_b)};
            8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87: alu_c = alu_a << alu_b[3:0];
            default: ;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        dbg_raddr = a;
        #1 d = dbg_rdata;
    endtask

    // issues one word; returns the cycle done was seen (0 = timeout), illegal/opcode/carry at done,
    // and whether inst_ready stayed low from cycle 1 through done
    task automatic run(input logic [15:0] w, input bit noise, output int dc, output logic ill,
                       output logic [7:0] op, output logic cy, output bit busy_ok);
        int n;
        n = 0;
        while (!inst_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        inst = w;
        inst_valid = 1'b1;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        dc = 0;
        busy_ok = 1'b1;
        ill = 1'b0;
        op = '0;
        cy = 1'b0;
        for (int c = 1; c <= 20 && dc == 0; c++) begin
            @(negedge clk);
            if (inst_ready) busy_ok = 1'b0;
            if (noise && c == 1) begin
                inst_valid = 1'b1;
                inst = 16'h5F7F;
            end
            if (noise && c == 2) inst_valid = 1'b0;
            if (done) begin
                dc = c;
                ill = illegal;
                op = alu_opcode;
                cy = alu_carry;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [15:0] r;
        @(negedge clk);
        checks++; if ({inst_ready, done, illegal} !== 3'b100) begin errors++; $display("FAIL reset_ctl: got %b expected 100", {inst_ready, done, illegal}); end
        checks++; if ({alu_opcode, alu_a, alu_b} !== 40'h0) begin errors++; $display("FAIL reset_alu: got %h expected 0", {alu_opcode, alu_a, alu_b}); end
        checks++; if (psr !== 5'h00) begin errors++; $display("FAIL reset_psr: got %h expected 00", psr); end
        @(negedge clk);
        reset_n = 1'b1;
        rd(4'd1, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL reset_r1: got %h expected 0000", r); end
    endtask

    task automatic test_addi;
        int dc; logic ill, cy; logic [7:0] op; bit bz; logic [15:0] r;
        run(16'h5105, 1'b0, dc, ill, op, cy, bz);
        checks++; if (dc !== LAT) begin errors++; $display("FAIL addi_latency: got %0d expected %0d", dc, LAT); end
        checks++; if (bz !== 1'b1) begin errors++; $display("FAIL addi_ready_low: got %b expected 1", bz); end
        checks++; if ({ill, op} !== {1'b0, 8'h50}) begin errors++; $display("FAIL addi_op: got %b/%h expected 0/50", ill, op); end
        checks++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL addi_ready_back: got %b expected 1", inst_ready); end
        rd(4'd1, r);
        checks++; if (r !== 16'h0005) begin errors++; $display("FAIL addi_r1: got %h expected 0005", r); end
        checks++; if (psr !== 5'h00) begin errors++; $display("FAIL addi_psr: got %h expected 00", psr); end
    endtask

    task automatic test_add_signed;
        int dc; logic ill, cy; logic [7:0] op; bit bz; logic [15:0] r;
        run(16'h52FF, 1'b0, dc, ill, op, cy, bz);
        rd(4'd2, r);
        checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL addi_neg_r2: got %h expected FFFF", r); end
        run(16'h0251, 1'b0, dc, ill, op, cy, bz);
        rd(4'd2, r);
        checks++; if (op !== 8'h05) begin errors++; $display("FAIL add_op: got %h expected 05", op); end
        checks++; if (r !== 16'h0004) begin errors++; $display("FAIL add_r2: got %h expected 0004", r); end
        checks++; if (psr !== 5'h08) begin errors++; $display("FAIL add_psr: got %h expected 08", psr); end
    endtask

    task automatic test_back_to_back;
        int dc; logic ill, cy; logic [7:0] op; bit bz; logic [15:0] r;
        run(16'h55FF, 1'b0, dc, ill, op, cy, bz);
        run(16'h6501, 1'b0, dc, ill, op, cy, bz);
        rd(4'd5, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL addui_r5: got %h expected 0000", r); end
        checks++; if (psr !== 5'h18) begin errors++; $display("FAIL addui_psr: got %h expected 18", psr); end
        run(16'h0640, 1'b0, dc, ill, op, cy, bz);
        rd(4'd6, r);
        checks++; if ({op, cy} !== {8'h04, 1'b1}) begin errors++; $display("FAIL addcu_op_carry: got %h/%b expected 04/1", op, cy); end
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL addcu_r6: got %h expected 0001", r); end
        checks++; if (psr !== 5'h00) begin errors++; $display("FAIL addcu_psr: got %h expected 00", psr); end
    endtask

    task automatic test_cmp;
        int dc; logic ill, cy; logic [7:0] op; bit bz; logic [15:0] r;
        run(16'hB106, 1'b0, dc, ill, op, cy, bz);
        rd(4'd1, r);
        checks++; if (psr !== 5'h03) begin errors++; $display("FAIL cmpi_psr: got %h expected 03", psr); end
        checks++; if (r !== 16'h0005) begin errors++; $display("FAIL cmpi_r1: got %h expected 0005", r); end
    endtask

    task automatic test_illegal_nop;
        int dc; logic ill, cy; logic [7:0] op; bit bz; logic [15:0] r;
        run(16'hD100, 1'b0, dc, ill, op, cy, bz);
        rd(4'd1, r);
        checks++; if ({dc == LAT, ill} !== 2'b11) begin errors++; $display("FAIL illegal_pulse: got done_cycle=%0d illegal=%b expected %0d/1", dc, ill, LAT); end
        checks++; if ({psr, r} !== {5'h03, 16'h0005}) begin errors++; $display("FAIL illegal_state: got psr=%h r1=%h expected 03/0005", psr, r); end
        run(16'h0000, 1'b0, dc, ill, op, cy, bz);
        rd(4'd1, r);
        checks++; if ({dc == LAT, ill} !== 2'b10) begin errors++; $display("FAIL nop_pulse: got done_cycle=%0d illegal=%b expected %0d/0", dc, ill, LAT); end
        checks++; if ({psr, r} !== {5'h03, 16'h0005}) begin errors++; $display("FAIL nop_state: got psr=%h r1=%h expected 03/0005", psr, r); end
    endtask

    task automatic test_shift_busy_ignore;
        int dc; logic ill, cy; logic [7:0] op; bit bz; logic [15:0] r;
        run(16'h8103, 1'b1, dc, ill, op, cy, bz);
        rd(4'd1, r);
        checks++; if (op !== 8'h80) begin errors++; $display("FAIL lshi_op: got %h expected 80", op); end
        checks++; if (r !== 16'h0028) begin errors++; $display("FAIL lshi_r1: got %h expected 0028", r); end
        checks++; if (psr !== 5'h00) begin errors++; $display("FAIL lshi_psr: got %h expected 00", psr); end
        rd(4'd15, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL busy_ignore_r15: got %h expected 0000", r); end
    endtask

    task automatic test_reset_mid;
        int dc; logic ill, cy; logic [7:0] op; bit bz; logic [15:0] r; bit seen;
        run(16'h55FF, 1'b0, dc, ill, op, cy, bz);
        run(16'h6501, 1'b0, dc, ill, op, cy, bz);
        checks++; if (psr !== 5'h18) begin errors++; $display("FAIL pre_abort_psr: got %h expected 18", psr); end
        inst = 16'h5107;
        inst_valid = 1'b1;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if ({inst_ready, done, psr} !== {1'b1, 1'b0, 5'h00}) begin errors++; $display("FAIL abort_ctl: got ready=%b done=%b psr=%h expected 1/0/00", inst_ready, done, psr); end
        rd(4'd1, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL abort_r1: got %h expected 0000", r); end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        rd(4'd1, r);
        checks++; if ({seen, r} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL abort_after: got done_seen=%b r1=%h expected 0/0000", seen, r); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add_signed();
        test_back_to_back();
        test_cmp();
        test_illegal_nop();
        test_shift_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
